// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues one req/ack read per instruction and loads the
// result into the IF/ID register, with a one-entry buffer that absorbs decode stalls.
`timescale 1ns/1ps

module fetch_stage #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [ADDR_W-1:0]  pcAddress,
    output logic               PCWrite,
    output logic [ADDR_W-1:0]  pcPlus4,
    output logic               imemReq,
    output logic [ADDR_W-1:0]  imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemData,
    input  logic               stallD,
    input  logic               flushF,
    output logic [INSTR_W-1:0] instrD,
    output logic [ADDR_W-1:0]  pcD,
    output logic               validD,
    output logic [1:0]         fsm_state
);

    // Handshake: a read is outstanding from the edge that raises imemReq until the
    // first edge that sees imemAck=1; imemAddr is stable over that whole window and
    // imemData is consumed on the ack edge only. One read in flight at a time.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               drop_pending;
    logic [INSTR_W-1:0] buf_instr;
    logic [ADDR_W-1:0]  buf_pc;

    logic ack_wait;
    logic discard;
    logic take_mem;
    logic to_buf;
    logic take_buf;
    logic issue;

    assign fsm_state = state;
    assign pcPlus4   = pcAddress + ADDR_W'(4);

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = WAIT;
            WAIT: begin
                if (imemAck) begin
                    if (flushF || drop_pending) begin
                        state_next = IDLE;
                    end else if (stallD) begin
                        state_next = FULL;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            FULL: begin
                if (flushF || !stallD) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output/decode logic
    always_comb begin
        ack_wait = (state == WAIT) && imemAck;
        discard  = ack_wait && (flushF || drop_pending);
        take_mem = ack_wait && !discard && !stallD;
        to_buf   = ack_wait && !discard && stallD;
        take_buf = (state == FULL) && !stallD && !flushF;
        issue    = (state == IDLE);
        // A flush moves the PC to the redirect target even if nothing was fetched.
        PCWrite  = !Reset && (flushF || take_mem || ((state == FULL) && !stallD));
    end

    // Memory request, drop flag and stall buffer
    always_ff @(posedge CLK) begin
        if (Reset) begin
            imemReq      <= 1'b0;
            imemAddr     <= '0;
            drop_pending <= 1'b0;
            buf_instr    <= NOP_INSTR;
            buf_pc       <= '0;
        end else begin
            if (issue) begin
                imemReq  <= 1'b1;
                imemAddr <= pcAddress;
            end else if (ack_wait) begin
                imemReq <= 1'b0;
            end

            // The read cannot be cancelled, so a flush mid-read marks its data as stale.
            if (ack_wait) begin
                drop_pending <= 1'b0;
            end else if ((state == WAIT) && flushF) begin
                drop_pending <= 1'b1;
            end

            if (to_buf) begin
                buf_instr <= imemData;
                buf_pc    <= imemAddr;
            end
        end
    end

    // IF/ID pipeline register: flush > stall > new instruction > bubble
    always_ff @(posedge CLK) begin
        if (Reset) begin
            instrD <= NOP_INSTR;
            pcD    <= '0;
            validD <= 1'b0;
        end else if (flushF) begin
            instrD <= NOP_INSTR;
            pcD    <= '0;
            validD <= 1'b0;
        end else if (stallD) begin
            instrD <= instrD;
            pcD    <= pcD;
            validD <= validD;
        end else if (take_mem) begin
            instrD <= imemData;
            pcD    <= imemAddr;
            validD <= 1'b1;
        end else if (take_buf) begin
            instrD <= buf_instr;
            pcD    <= buf_pc;
            validD <= 1'b1;
        end else begin
            instrD <= NOP_INSTR;
            validD <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, each cycle's expected
// outputs come from a transaction-level model and are checked through a queue.
`timescale 1ns/1ps

module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] pcAddress;
    logic        PCWrite;
    logic [31:0] pcPlus4;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        stallD;
    logic        flushF;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        validD;
    logic [1:0]  fsm_state;

    always #5 CLK = ~CLK;

    fetch_stage #(.ADDR_W(32), .INSTR_W(32), .NOP_INSTR(NOP)) dut (
        .CLK(CLK), .Reset(Reset), .pcAddress(pcAddress), .PCWrite(PCWrite),
        .pcPlus4(pcPlus4), .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck),
        .imemData(imemData), .stallD(stallD), .flushF(flushF), .instrD(instrD),
        .pcD(pcD), .validD(validD), .fsm_state(fsm_state)
    );

    typedef struct packed {
        logic        pcwrite;
        logic [31:0] pcplus4;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic        valid;
        logic [1:0]  state;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: one outstanding read, one held instruction, the IF/ID contents.
    logic [31:0] pc;
    bit          m_req, m_drop, m_held, m_valid;
    logic [31:0] m_addr, m_hold_instr, m_hold_pc, m_instr, m_pc;

    task automatic model_reset();
        m_req = 0; m_drop = 0; m_held = 0; m_valid = 0;
        m_addr = 0; m_instr = NOP; m_pc = 0; m_hold_instr = 0; m_hold_pc = 0;
    endtask

    // Drive one cycle of inputs, queue the expected outputs, advance the model.
    task automatic cycle(input bit rst, input bit ack, input logic [31:0] data,
                         input bit stall, input bit flush, input logic [31:0] target);
        snap_t s;
        bit ack_seen, usable, from_mem, from_buf, pcw, was_idle;
        Reset = rst; imemAck = ack; imemData = data;
        stallD = stall; flushF = flush; pcAddress = pc;

        was_idle = !m_req && !m_held;
        ack_seen = m_req && ack;
        usable   = ack_seen && !flush && !m_drop;
        from_mem = usable && !stall;
        from_buf = m_held && !stall && !flush;
        pcw      = !rst && (flush || from_mem || from_buf);

        s.pcwrite = pcw;
        s.pcplus4 = pc + 32'd4;
        s.req     = m_req;
        s.addr    = m_addr;
        s.instr   = m_instr;
        s.pcd     = m_pc;
        s.valid   = m_valid;
        s.state   = m_held ? 2'd2 : (m_req ? 2'd1 : 2'd0);
        exp_q.push_back(s);

        if (rst) begin
            model_reset();
        end else begin
            if (flush) begin
                m_instr = NOP; m_pc = 0; m_valid = 0;
            end else if (!stall) begin
                if (from_mem) begin
                    m_instr = data; m_pc = m_addr; m_valid = 1;
                end else if (from_buf) begin
                    m_instr = m_hold_instr; m_pc = m_hold_pc; m_valid = 1;
                end else begin
                    m_instr = NOP; m_valid = 0;
                end
            end
            if (m_held) begin
                if (flush || !stall) m_held = 0;
            end else if (usable && stall) begin
                m_held = 1; m_hold_instr = data; m_hold_pc = m_addr;
            end
            if (was_idle) begin
                m_req = 1; m_addr = pc;
            end else if (ack_seen) begin
                m_req = 0; m_drop = 0;
            end else if (m_req && flush) begin
                m_drop = 1;
            end
        end
        if (pcw) pc = flush ? target : pc + 32'd4;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("PCWrite",   {31'd0, PCWrite}, {31'd0, e.pcwrite});
            chk("pcPlus4",   pcPlus4,          e.pcplus4);
            chk("imemReq",   {31'd0, imemReq}, {31'd0, e.req});
            chk("imemAddr",  imemAddr,         e.addr);
            chk("instrD",    instrD,           e.instr);
            chk("pcD",       pcD,              e.pcd);
            chk("validD",    {31'd0, validD},  {31'd0, e.valid});
            chk("fsm_state", {30'd0, fsm_state}, {30'd0, e.state});
        end
    end

    initial begin
        Reset = 1; imemAck = 0; imemData = 0; stallD = 0; flushF = 0;
        pc = 32'h100; pcAddress = pc;
        @(posedge CLK);
        #1;
        model_reset();

        // Reset, then single-cycle ack
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h8C01_0004, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // Ack three cycles after the request
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h1111_2222, 0, 0, 0);
        // Stall on the ack cycle and two more
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h3333_4444, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // Flush while waiting, late ack dropped, refetch at 0x200
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h200);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h5555_6666, 0, 0, 0);
        // Flush + stall + ack together
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h7777_8888, 1, 1, 32'h300);
        cycle(0, 0, 0, 0, 0, 0);
        // Reset in WAIT, late ack afterwards
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'hBAD0_0001, 0, 0, 0);
        cycle(0, 1, 32'h9999_0000, 0, 0, 0);
        // Reset in FULL
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'hAAAA_BBBB, 1, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'hCCCC_DDDD, 0, 0, 0);
        // pcPlus4 wrap
        pc = 32'hFFFF_FFFC;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h0BAD_F00D, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 49) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom(),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom() & 32'hFFFF_FFFC);
        end

        @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
